// File: rtl/bp_vc_evict_drain.sv
// +----------------------------------------------------------------------------+
// | bp_vc_evict_drain: drains dirty victim lines to memory one beat at a time; |
// | clean victims are accepted and dropped.                                    |
// | Optional feature macro: BP_VC_DRAIN_STATS_EN (writeback/drop counters).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_vc_evict_drain #(
    parameter int block_width = 512,
    parameter int tag_width   = 20,
    parameter int stat_width  = 2,
    parameter int beat_width  = 64,
    parameter int dirty_bit   = 1
) (
    input  logic                                          clk_i,
    input  logic                                          reset,
    input  logic                                          evict_v_i,
    output logic                                          evict_ready_o,
    input  logic [block_width-1:0]                        evict_data_i,
    input  logic [tag_width-1:0]                          evict_tag_i,
    input  logic [stat_width-1:0]                         evict_stat_i,
    output logic                                          mem_v_o,
    input  logic                                          mem_ready_i,
    output logic [tag_width-1:0]                          mem_tag_o,
    output logic [$clog2(block_width/beat_width)-1:0]     mem_beat_o,
    output logic [beat_width-1:0]                         mem_data_o,
    output logic                                          mem_last_o
`ifdef BP_VC_DRAIN_STATS_EN
    ,
    output logic [31:0]                                   wb_count_o,
    output logic [31:0]                                   drop_count_o
`endif
);

    localparam int num_beats      = block_width / beat_width;
    localparam int beat_idx_width = $clog2(num_beats);
    localparam logic [beat_idx_width-1:0] last_beat = beat_idx_width'(num_beats - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                state;
    logic [0:0]                next_state;
    logic [beat_idx_width-1:0] beat;
    logic [block_width-1:0]    hold_data;
    logic [tag_width-1:0]      hold_tag;

    logic dirty;
    logic in_send;
    logic at_last;
    logic beat_hs;
    logic wb_hs;
    logic accept;
    logic capture;
    logic drop;
    logic unused_stat;

    assign dirty       = evict_stat_i[dirty_bit];
    assign unused_stat = ^evict_stat_i;
    assign in_send     = (state == SEND);
    assign at_last     = (beat == last_beat);
    assign beat_hs     = in_send & mem_ready_i;
    assign wb_hs       = beat_hs & at_last;
    assign accept      = evict_v_i & evict_ready_o;
    assign capture     = accept & dirty;
    assign drop        = accept & ~dirty;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a dirty line taken on the last-beat handshake keeps us in SEND
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (wb_hs) begin
                    next_state = capture ? SEND : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is asserted
    always_comb begin
        evict_ready_o = 1'b0;
        mem_v_o       = 1'b0;
        mem_tag_o     = '0;
        mem_beat_o    = '0;
        mem_data_o    = '0;
        mem_last_o    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    evict_ready_o = 1'b1;
                end
                SEND: begin
                    mem_v_o       = 1'b1;
                    mem_tag_o     = hold_tag;
                    mem_beat_o    = beat;
                    mem_data_o    = hold_data[beat_width-1:0];
                    mem_last_o    = at_last;
                    evict_ready_o = mem_ready_i & at_last;
                end
                default: begin
                    evict_ready_o = 1'b0;
                end
            endcase
        end
    end

    // Held line is shifted down one beat per handshake so the current beat is always the LSBs
    always_ff @(posedge clk_i) begin
        if (reset) begin
            beat      <= '0;
            hold_data <= '0;
            hold_tag  <= '0;
        end else if (capture) begin
            beat      <= '0;
            hold_data <= evict_data_i;
            hold_tag  <= evict_tag_i;
        end else if (beat_hs) begin
            hold_data <= hold_data >> beat_width;
            beat      <= at_last ? '0 : beat + beat_idx_width'(1);
        end
    end

`ifdef BP_VC_DRAIN_STATS_EN
    logic [31:0] wb_count;
    logic [31:0] drop_count;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wb_count   <= '0;
            drop_count <= '0;
        end else begin
            if (wb_hs && (wb_count != 32'hFFFF_FFFF)) begin
                wb_count <= wb_count + 32'd1;
            end
            if (drop && (drop_count != 32'hFFFF_FFFF)) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    assign wb_count_o   = wb_count;
    assign drop_count_o = drop_count;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_vc_evict_drain.sv
// Directed bench for bp_vc_evict_drain at default geometry (8 beats of 64 bits).
`default_nettype none

module tb_bp_vc_evict_drain;

    localparam int BW = 512;
    localparam int TW = 20;
    localparam int SW = 2;
    localparam int DW = 64;
    localparam int NB = 8;

    localparam logic [63:0] PAT_A = 64'h1111_1111_1111_1111;
    localparam logic [63:0] PAT_B = 64'h0102_0304_0506_0708;
    localparam logic [63:0] OFS_B = 64'hDEAD_0000_0000_BEEF;

    logic          clk_i = 1'b0;
    logic          reset = 1'b0;
    logic          evict_v_i = 1'b0;
    logic          evict_ready_o;
    logic [BW-1:0] evict_data_i = '0;
    logic [TW-1:0] evict_tag_i = '0;
    logic [SW-1:0] evict_stat_i = '0;
    logic          mem_v_o;
    logic          mem_ready_i = 1'b0;
    logic [TW-1:0] mem_tag_o;
    logic [2:0]    mem_beat_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_last_o;
`ifdef BP_VC_DRAIN_STATS_EN
    logic [31:0]   wb_count_o;
    logic [31:0]   drop_count_o;
`endif

    int total = 0;
    int bad   = 0;

    bp_vc_evict_drain dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .evict_v_i    (evict_v_i),
        .evict_ready_o(evict_ready_o),
        .evict_data_i (evict_data_i),
        .evict_tag_i  (evict_tag_i),
        .evict_stat_i (evict_stat_i),
        .mem_v_o      (mem_v_o),
        .mem_ready_i  (mem_ready_i),
        .mem_tag_o    (mem_tag_o),
        .mem_beat_o   (mem_beat_o),
        .mem_data_o   (mem_data_o),
        .mem_last_o   (mem_last_o)
`ifdef BP_VC_DRAIN_STATS_EN
        ,
        .wb_count_o   (wb_count_o),
        .drop_count_o (drop_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [BW-1:0] mk_line(input logic [63:0] base, input logic [63:0] ofs);
        logic [BW-1:0] l;
        for (int k = 0; k < NB; k++) begin
            l[k*DW +: DW] = base * 64'(k) + ofs;
        end
        return l;
    endfunction

    // Stimulus only: pulse reset for two cycles with idle inputs, end at a negedge
    task automatic apply_reset();
        @(negedge clk_i);
        reset = 1'b1; evict_v_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset = 1'b0;
        @(negedge clk_i);
    endtask

    // Stimulus only: offer a line at the current negedge; it is taken at the next posedge
    task automatic offer_line(input logic [TW-1:0] tag, input logic [SW-1:0] stat,
                              input logic [BW-1:0] data);
        evict_v_i = 1'b1; evict_tag_i = tag; evict_stat_i = stat; evict_data_i = data;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset = 1'b1; mem_ready_i = 1'b1;
        offer_line(20'h12345, 2'b10, mk_line(PAT_A, 64'd0));
        #1;
        total++; if (evict_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", evict_ready_o); end
        total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL reset_mem_v got=%b want=0", mem_v_o); end
        total++; if (mem_last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", mem_last_o); end
        total++; if ({mem_tag_o, mem_beat_o, mem_data_o} !== '0) begin bad++;
            $display("FAIL reset_outs got tag=%h beat=%0d data=%h want 0", mem_tag_o, mem_beat_o, mem_data_o); end
        @(negedge clk_i);
        evict_v_i = 1'b0;
        @(negedge clk_i);
        reset = 1'b0;
        #1;
        total++; if (evict_ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", evict_ready_o); end
        total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL idle_mem_v got=%b want=0", mem_v_o); end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if ({wb_count_o, drop_count_o} !== 64'd0) begin bad++;
            $display("FAIL reset_counts got wb=%0d drop=%0d want 0", wb_count_o, drop_count_o); end
`endif
        @(negedge clk_i);
    endtask

    task automatic test_dirty_line();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h12345, 2'b10, mk_line(PAT_A, 64'd0));
        #1;
        total++; if (evict_ready_o !== 1'b1 || mem_v_o !== 1'b0) begin bad++;
            $display("FAIL dirty_accept got ready=%b v=%b want 1/0", evict_ready_o, mem_v_o); end
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int k = 0; k < NB; k++) begin
            #1;
            total++; if (mem_v_o !== 1'b1 || mem_beat_o !== 3'(k)) begin bad++;
                $display("FAIL dirty_beat k=%0d got v=%b beat=%0d", k, mem_v_o, mem_beat_o); end
            total++; if (mem_data_o !== PAT_A * 64'(k)) begin bad++;
                $display("FAIL dirty_data k=%0d got=%h want=%h", k, mem_data_o, PAT_A * 64'(k)); end
            total++; if (mem_tag_o !== 20'h12345 || mem_last_o !== (k == NB - 1)) begin bad++;
                $display("FAIL dirty_tag_last k=%0d got tag=%h last=%b", k, mem_tag_o, mem_last_o); end
            total++; if (evict_ready_o !== (k == NB - 1)) begin bad++;
                $display("FAIL dirty_ready k=%0d got=%b", k, evict_ready_o); end
            @(negedge clk_i);
        end
        #1;
        total++; if (mem_v_o !== 1'b0 || evict_ready_o !== 1'b1) begin bad++;
            $display("FAIL dirty_done got v=%b ready=%b want 0/1", mem_v_o, evict_ready_o); end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if (wb_count_o !== 32'd1) begin bad++; $display("FAIL dirty_wb got=%0d want=1", wb_count_o); end
`endif
        @(negedge clk_i);
    endtask

    task automatic test_clean_drop();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h0BEEF, 2'b00, mk_line(PAT_B, OFS_B));
        #1;
        total++; if (evict_ready_o !== 1'b1) begin bad++; $display("FAIL clean_ready got=%b want=1", evict_ready_o); end
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (mem_v_o !== 1'b0 || evict_ready_o !== 1'b1) begin bad++;
                $display("FAIL clean_idle c=%0d got v=%b ready=%b want 0/1", c, mem_v_o, evict_ready_o); end
            @(negedge clk_i);
        end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if (drop_count_o !== 32'd1 || wb_count_o !== 32'd0) begin bad++;
            $display("FAIL clean_counts got drop=%0d wb=%0d want 1/0", drop_count_o, wb_count_o); end
`endif
    endtask

    task automatic test_stall();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h00ABC, 2'b10, mk_line(PAT_A, 64'd0));
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == 3) begin
                for (int s = 0; s < 5; s++) begin
                    mem_ready_i = 1'b0;
                    #1;
                    total++; if (mem_v_o !== 1'b1 || mem_beat_o !== 3'd3 || mem_data_o !== PAT_A * 64'd3) begin bad++;
                        $display("FAIL stall_hold s=%0d got v=%b beat=%0d data=%h", s, mem_v_o, mem_beat_o, mem_data_o); end
                    total++; if (evict_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready s=%0d got=%b want=0", s, evict_ready_o); end
                    @(negedge clk_i);
                end
            end
            mem_ready_i = 1'b1;
            #1;
            total++; if (mem_beat_o !== 3'(k) || mem_data_o !== PAT_A * 64'(k)) begin bad++;
                $display("FAIL stall_beat k=%0d got beat=%0d data=%h", k, mem_beat_o, mem_data_o); end
            @(negedge clk_i);
        end
        #1;
        total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL stall_done got v=%b want=0", mem_v_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h12345, 2'b10, mk_line(PAT_A, 64'd0));
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int n = 0; n < 2 * NB; n++) begin
            if (n == NB - 1) offer_line(20'h0ABCD, 2'b11, mk_line(PAT_B, OFS_B));
            else evict_v_i = 1'b0;
            #1;
            total++; if (mem_v_o !== 1'b1 || mem_beat_o !== 3'(n % NB)) begin bad++;
                $display("FAIL b2b_beat n=%0d got v=%b beat=%0d", n, mem_v_o, mem_beat_o); end
            if (n < NB) begin
                total++; if (mem_data_o !== PAT_A * 64'(n) || mem_tag_o !== 20'h12345) begin bad++;
                    $display("FAIL b2b_first n=%0d got data=%h tag=%h", n, mem_data_o, mem_tag_o); end
            end else begin
                total++; if (mem_data_o !== PAT_B * 64'(n - NB) + OFS_B || mem_tag_o !== 20'h0ABCD) begin bad++;
                    $display("FAIL b2b_second n=%0d got data=%h tag=%h", n, mem_data_o, mem_tag_o); end
            end
            if (n == NB - 1) begin
                total++; if (evict_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", evict_ready_o); end
            end
            @(negedge clk_i);
        end
        evict_v_i = 1'b0;
        #1;
        total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL b2b_done got v=%b want=0", mem_v_o); end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if (wb_count_o !== 32'd2) begin bad++; $display("FAIL b2b_wb got=%0d want=2", wb_count_o); end
`endif
    endtask

    task automatic test_clean_at_last();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h00777, 2'b10, mk_line(PAT_A, 64'd0));
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == NB - 1) offer_line(20'h00888, 2'b01, mk_line(PAT_B, OFS_B));
            #1;
            if (k == NB - 1) begin
                total++; if (evict_ready_o !== 1'b1 || mem_last_o !== 1'b1) begin bad++;
                    $display("FAIL cl_last got ready=%b last=%b want 1/1", evict_ready_o, mem_last_o); end
            end
            @(negedge clk_i);
        end
        evict_v_i = 1'b0;
        #1;
        total++; if (mem_v_o !== 1'b0 || evict_ready_o !== 1'b1) begin bad++;
            $display("FAIL cl_idle got v=%b ready=%b want 0/1", mem_v_o, evict_ready_o); end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if (drop_count_o !== 32'd1 || wb_count_o !== 32'd1) begin bad++;
            $display("FAIL cl_counts got drop=%0d wb=%0d want 1/1", drop_count_o, wb_count_o); end
`endif
    endtask

    task automatic test_reset_mid_line();
        apply_reset();
        mem_ready_i = 1'b1;
        offer_line(20'h12345, 2'b10, mk_line(PAT_A, 64'd0));
        @(negedge clk_i);
        evict_v_i = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk_i);
        #1;
        total++; if (mem_beat_o !== 3'd4) begin bad++; $display("FAIL rm_at4 got beat=%0d want=4", mem_beat_o); end
        reset = 1'b1;
        #1;
        total++; if (mem_v_o !== 1'b0 || evict_ready_o !== 1'b0) begin bad++;
            $display("FAIL rm_during got v=%b ready=%b want 0/0", mem_v_o, evict_ready_o); end
        @(negedge clk_i);
        reset = 1'b0;
        #1;
        total++; if (mem_v_o !== 1'b0 || evict_ready_o !== 1'b1) begin bad++;
            $display("FAIL rm_after got v=%b ready=%b want 0/1", mem_v_o, evict_ready_o); end
        offer_line(20'h00042, 2'b10, mk_line(PAT_B, OFS_B));
        @(negedge clk_i);
        evict_v_i = 1'b0;
        #1;
        total++; if (mem_v_o !== 1'b1 || mem_beat_o !== 3'd0 || mem_data_o !== OFS_B || mem_tag_o !== 20'h00042) begin bad++;
            $display("FAIL rm_new got v=%b beat=%0d data=%h tag=%h", mem_v_o, mem_beat_o, mem_data_o, mem_tag_o); end
`ifdef BP_VC_DRAIN_STATS_EN
        total++; if (wb_count_o !== 32'd0) begin bad++; $display("FAIL rm_wb got=%0d want=0", wb_count_o); end
`endif
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_dirty_line();
        test_clean_drop();
        test_stall();
        test_back_to_back();
        test_clean_at_last();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
